// File: rtl/sd_spi.sv
// sd_spi: SPI mode-0 master for the SD slot. Handles byte transfers, chip-select control and the 80-clock init burst.
// Build option SD_SPI_CRC7_EN adds a crc7 output: the CRC7 of every bit that byte transfers shift out.
module sd_spi #(
  parameter int DIV_SLOW = 31,
  parameter int DIV_FAST = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  input  logic       fast,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       sd_cs_n
`ifdef SD_SPI_CRC7_EN
  ,
  output logic [6:0] crc7
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // CS    | chip-select command, one cycle
  // LO    | sd_clk low half-period
  // HI    | sd_clk high half-period
  // FIN   | one-cycle wrap-up, dout update
  typedef enum logic [2:0] {ST_IDLE, ST_CS, ST_LO, ST_HI, ST_FIN} state_t;

  localparam int DMAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CW   = (DMAX < 1) ? 1 : $clog2(DMAX + 1);
  localparam logic [CW-1:0] D_SLOW = CW'(DIV_SLOW);
  localparam logic [CW-1:0] D_FAST = CW'(DIV_FAST);

  localparam logic [1:0] CMD_XFER   = 2'd0;
  localparam logic [1:0] CMD_CS_ON  = 2'd1;
  localparam logic [1:0] CMD_CS_OFF = 2'd2;
  localparam logic [1:0] CMD_INIT   = 2'd3;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_cmd;
  logic [CW-1:0]   r_div, r_cnt, w_start_div;
  logic [6:0]      r_bit;
  logic [7:0]      r_shift_out, r_shift_in, r_dout;
  logic            r_sd_clk, r_mosi, r_cs_n, r_done;
  logic            w_tick, w_last;

  assign w_tick      = (r_cnt == '0);
  assign w_last      = (r_cmd == CMD_INIT) ? (r_bit == 7'd79) : (r_bit == 7'd7);
  assign w_start_div = (fast && (cmd != CMD_INIT)) ? D_FAST : D_SLOW;

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign dout    = r_dout;
  assign sd_clk  = r_sd_clk;
  assign sd_mosi = r_mosi;
  assign sd_cs_n = r_cs_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ((cmd == CMD_CS_ON) || (cmd == CMD_CS_OFF)) ? ST_CS : ST_LO;
      ST_CS:   w_state_nxt = ST_FIN;
      ST_LO:   if (w_tick) w_state_nxt = ST_HI;
      ST_HI:   if (w_tick) w_state_nxt = w_last ? ST_FIN : ST_LO;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd       <= CMD_XFER;
      r_div       <= D_SLOW;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift_out <= '0;
      r_shift_in  <= '0;
      r_sd_clk    <= 1'b0;
      r_mosi      <= 1'b1;
      r_cs_n      <= 1'b1;
      r_done      <= 1'b0;
      r_dout      <= 8'hFF;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_cmd <= cmd;
          r_div <= w_start_div;
          r_cnt <= w_start_div;
          r_bit <= '0;
          case (cmd)
            CMD_XFER: begin
              r_shift_out <= din;
              r_mosi      <= din[7];
            end
            CMD_CS_ON:  r_cs_n <= 1'b0;
            CMD_CS_OFF: r_cs_n <= 1'b1;
            default: begin
              r_cs_n <= 1'b1;
              r_mosi <= 1'b1;
            end
          endcase
        end
        ST_LO: begin
          if (w_tick) begin
            r_sd_clk <= 1'b1;
            r_cnt    <= r_div;
            if (r_cmd == CMD_XFER) r_shift_in <= {r_shift_in[6:0], sd_miso};
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_HI: begin
          if (w_tick) begin
            r_sd_clk <= 1'b0;
            r_cnt    <= r_div;
            if (!w_last) begin
              r_bit <= r_bit + 7'd1;
              if (r_cmd == CMD_XFER) begin
                r_mosi      <= r_shift_out[6];
                r_shift_out <= {r_shift_out[6:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_FIN: begin
          r_mosi <= 1'b1;
          r_done <= 1'b1;
          if (r_cmd == CMD_XFER) r_dout <= r_shift_in;
        end
        default: ;
      endcase
    end
  end

`ifdef SD_SPI_CRC7_EN
  logic [6:0] r_crc;

  function automatic logic [6:0] f_crc7(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
  endfunction

  // Advances in step with every bit placed on sd_mosi by a byte transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      if (cmd == CMD_XFER)       r_crc <= f_crc7(r_crc, din[7]);
      else if (cmd == CMD_CS_ON) r_crc <= '0;
    end else if ((r_state == ST_HI) && w_tick && !w_last && (r_cmd == CMD_XFER)) begin
      r_crc <= f_crc7(r_crc, r_shift_out[6]);
    end
  end

  assign crc7 = r_crc;
`endif

endmodule

// File: tb/tb_sd_spi.sv
// tb_sd_spi: directed bench for sd_spi with a MISO card model and queue scoreboards for MOSI bits and dout.
module tb_sd_spi;
  logic       clock = 1'b0, reset_n = 1'b1, start = 1'b0, fast = 1'b0, sd_miso = 1'b1;
  logic [1:0] cmd = 2'd0;
  logic [7:0] din = 8'd0;
  logic       busy, done, sd_clk, sd_mosi, sd_cs_n;
  logic [7:0] dout;
`ifdef SD_SPI_CRC7_EN
  logic [6:0] crc7;
`endif

  int   n_checks = 0, n_err = 0;
  logic [7:0] miso_byte = 8'hFF;
  logic [7:0] last_dout = 8'hFF;
  logic       mosi_q[$];
  logic [7:0] dout_q[$];
  bit   init_mode = 1'b0;
  int   cyc = 0, rises = 0, falls = 0, t_start = 0, t_r1 = 0, t_r2 = 0, t_f1 = 0, t_flast = 0;
  int   busy_cyc = 0, dones = 0, bit_idx = 0;
  logic prev_clk = 1'b0, prev_busy = 1'b0;

  sd_spi dut (
    .clock(clock), .reset_n(reset_n), .start(start), .cmd(cmd), .din(din), .fast(fast),
    .busy(busy), .done(done), .dout(dout), .sd_clk(sd_clk), .sd_mosi(sd_mosi),
    .sd_miso(sd_miso), .sd_cs_n(sd_cs_n)
`ifdef SD_SPI_CRC7_EN
    , .crc7(crc7)
`endif
  );

  always #20 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Card model and scoreboard consumer, sampled on the falling clock edge.
  always @(negedge clock) begin
    logic [2:0] idx;
    cyc++;
    if (reset_n) begin
      if (busy && !prev_busy) begin
        rises = 0; falls = 0; busy_cyc = 0; dones = 0; t_start = cyc;
      end
      if (busy) busy_cyc++;
      if (sd_clk && !prev_clk) begin
        rises++;
        if (rises == 1) t_r1 = cyc;
        if (rises == 2) t_r2 = cyc;
        if (init_mode) chk("init_cs_mosi", {sd_cs_n, sd_mosi}, 2'b11);
        else if (mosi_q.size() > 0) chk("mosi_bit", sd_mosi, mosi_q.pop_front());
        bit_idx++;
        idx = 3'(7 - bit_idx);
        sd_miso = (bit_idx < 8) ? miso_byte[idx] : 1'b1;
      end
      if (!sd_clk && prev_clk) begin
        falls++;
        if (falls == 1) t_f1 = cyc;
        t_flast = cyc;
      end
      if (done) begin
        dones++;
        chk("done_busy_low", busy, 0);
        if (dout_q.size() > 0) chk("dout", dout, dout_q.pop_front());
      end
      if (!busy) begin
        bit_idx = 0;
        sd_miso = miso_byte[7];
      end
    end
    prev_clk  = sd_clk;
    prev_busy = busy;
  end

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic f);
    @(negedge clock); #1;
    cmd = c; din = d; fast = f; start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
  endtask

  task automatic xfer_start(input logic [7:0] d, input logic [7:0] mb, input logic f);
    for (int i = 7; i >= 0; i--) mosi_q.push_back(d[i]);
    dout_q.push_back(mb);
    last_dout = mb;
    miso_byte = mb;
    issue(2'd0, d, f);
  endtask

  task automatic wait_done(input string tag, input int lim);
    bit got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clock);
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, got, 1);
    repeat (3) @(negedge clock);
    chk({tag, "_one_done"}, dones, 1);
  endtask

  initial begin
    #5 reset_n = 1'b0;
    #5;
    chk("rst_cs_n", sd_cs_n, 1);
    chk("rst_sd_clk", sd_clk, 0);
    chk("rst_mosi", sd_mosi, 1);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #40 reset_n = 1'b1;
    repeat (2) @(negedge clock);

    issue(2'd1, 8'h00, 1'b0);
    wait_done("cs_on", 20);
    chk("cs_on_level", sd_cs_n, 0);
    chk("cs_on_busy_cycles", busy_cyc, 2);
    issue(2'd2, 8'h00, 1'b0);
    wait_done("cs_off", 20);
    chk("cs_off_level", sd_cs_n, 1);
    chk("cs_off_busy_cycles", busy_cyc, 2);

    issue(2'd1, 8'h00, 1'b0);
    wait_done("cs_on2", 20);
    xfer_start(8'hA5, 8'h3C, 1'b1);
    wait_done("fast_a5", 100);
    chk("fast_first_rise", t_r1 - t_start, 1);
    chk("fast_period", t_r2 - t_r1, 2);
    chk("fast_total", t_flast - t_start, 16);
    chk("fast_rises", rises, 8);
    chk("fast_busy_cycles", busy_cyc, 17);
    chk("cs_persists", sd_cs_n, 0);

    xfer_start(8'hFF, 8'h00, 1'b0);
    wait_done("slow_ff", 700);
    chk("slow_first_rise", t_r1 - t_start, 32);
    chk("slow_high_time", t_f1 - t_r1, 32);
    chk("slow_period", t_r2 - t_r1, 64);
    chk("slow_total", t_flast - t_start, 512);
    chk("slow_rises", rises, 8);

    xfer_start(8'hC3, 8'h81, 1'b1);
    repeat (5) @(negedge clock);
    #1;
    cmd = 2'd0; din = 8'h00; fast = 1'b0; start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    wait_done("ignore", 100);
    chk("ignore_total", t_flast - t_start, 16);
    chk("ignore_rises", rises, 8);
    chk("ignore_mosi_drained", mosi_q.size(), 0);

    init_mode = 1'b1;
    dout_q.push_back(last_dout);
    issue(2'd3, 8'h00, 1'b1);
    wait_done("init", 6000);
    init_mode = 1'b0;
    chk("init_rises", rises, 80);
    chk("init_first_rise", t_r1 - t_start, 32);
    chk("init_total", t_flast - t_start, 5120);
    chk("init_cs_after", sd_cs_n, 1);
    chk("init_dout_kept", dout, 8'h81);

`ifdef SD_SPI_CRC7_EN
    issue(2'd1, 8'h00, 1'b0);
    wait_done("crc_cs_on", 20);
    xfer_start(8'h40, 8'hFF, 1'b1);
    wait_done("crc_b0", 100);
    for (int k = 0; k < 4; k++) begin
      xfer_start(8'h00, 8'hFF, 1'b1);
      wait_done("crc_bn", 100);
    end
    chk("crc7_cmd0", crc7, 7'h4A);
    chk("crc_byte_cmd0", {crc7, 1'b1}, 8'h95);
`endif

    issue(2'd1, 8'h00, 1'b0);
    wait_done("cs_on3", 20);
    xfer_start(8'h12, 8'h00, 1'b0);
    repeat (40) @(negedge clock);
    chk("pre_rst_sd_clk", sd_clk, 1);
    chk("pre_rst_cs_n", sd_cs_n, 0);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_sd_clk", sd_clk, 0);
    chk("arst_mosi", sd_mosi, 1);
    chk("arst_cs_n", sd_cs_n, 1);
    chk("arst_busy", busy, 0);
    chk("arst_dout", dout, 8'hFF);
    chk("arst_done", done, 0);
    mosi_q.delete();
    dout_q.delete();
    #30 reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sd_clk", sd_clk, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end
endmodule
